// File: rtl/masked_share_encoder.sv
// masked_share_encoder
//
// Splits each plain data word into two Boolean shares (share0 ^ share1 = data)
// at the entry of the masked gadget datapath. It also hands out, with every
// word, three words of fresh per-bit randomness (r0/r1/r2) for the downstream
// masked XOR/AND gadgets. All random bits come from an internal 32-bit
// Fibonacci LFSR through a fill-then-use pool. The pool is emptied on every
// capture and has to be refilled completely before the next word can be
// accepted, so no random bit is ever used twice.
//
// Parameters
//   WIDTH      data/share width in bits (1..16)
//   LFSR_SEED  reset seed; also used when an all-zero seed is loaded
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   seed_load   synchronous reseed strobe (restarts the pool fill)
//   seed_in     seed value taken when seed_load=1
//   in_valid    in_data is valid
//   in_ready    word is accepted this cycle (never depends on in_valid)
//   in_data     plain data word
//   out_valid   shares and randomness are valid
//   out_ready   downstream accepts the output word
//   out_share0  in_data ^ mask
//   out_share1  mask
//   out_r0/1/2  fresh gadget randomness for this word
//
// State | meaning
// ------+----------------------------------------------------------------
// FILL  | pool shifts in one LFSR bit per cycle; no word accepted
// ARMED | pool full and frozen; waits for an input word to capture

module masked_share_encoder #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_share0,
  output logic [WIDTH-1:0] out_share1,
  output logic [WIDTH-1:0] out_r0,
  output logic [WIDTH-1:0] out_r1,
  output logic [WIDTH-1:0] out_r2
);

  localparam int POOL = 4 * WIDTH;
  localparam int CW   = $clog2(POOL + 1);

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [31:0]       lfsr_q;
  logic              fb;
  logic [POOL-1:0]   pool_q;
  logic [CW-1:0]     fill_cnt_q;
  logic              capture;
  logic [31:0]       seed_eff;

  // Taps 32,22,2,1 (maximal length); the register can only reach all-zeros
  // through a zero seed, which is replaced by LFSR_SEED below.
  assign fb       = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
  assign seed_eff = (seed_in == 32'd0) ? LFSR_SEED : seed_in;

  // ---------------------------------------------------------------------------
  // Next-state and handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    capture  = 1'b0;
    case (state_q)
      FILL: begin
        // The last fill cycle is the one that brings fill_cnt up to POOL.
        if (fill_cnt_q == CW'(POOL - 1)) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        // A reseed cycle blocks the capture so the old pool is never used.
        in_ready = !seed_load && (!out_valid || out_ready);
        capture  = in_ready && in_valid;
        if (capture) begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
    if (seed_load) begin
      state_d = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // LFSR: free-running except when reseeded
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (seed_load) begin
      lfsr_q <= seed_eff;
    end else begin
      lfsr_q <= {lfsr_q[30:0], fb};
    end
  end

  // ---------------------------------------------------------------------------
  // Randomness pool: shifts only while filling, frozen while armed
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pool_q     <= '0;
      fill_cnt_q <= '0;
    end else if (seed_load || capture) begin
      pool_q     <= '0;
      fill_cnt_q <= '0;
    end else if (state_q == FILL) begin
      pool_q     <= {pool_q[POOL-2:0], fb};
      fill_cnt_q <= fill_cnt_q + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  // A capture can only happen when the slot is empty or draining this cycle,
  // so loading on capture never overwrites an unaccepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_share0 <= '0;
      out_share1 <= '0;
      out_r0     <= '0;
      out_r1     <= '0;
      out_r2     <= '0;
    end else begin
      if (capture) begin
        out_valid  <= 1'b1;
        out_share1 <= pool_q[WIDTH-1:0];
        out_share0 <= in_data ^ pool_q[WIDTH-1:0];
        out_r0     <= pool_q[2*WIDTH-1:WIDTH];
        out_r1     <= pool_q[3*WIDTH-1:2*WIDTH];
        out_r2     <= pool_q[4*WIDTH-1:3*WIDTH];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
